// File: rtl/rasterizer_pkg.sv
// Shared rasterizer types: set-up triangle, emitted pixel, traverser bounding box and FSM state.
package rasterizer_pkg;

  typedef struct packed {
    logic signed [15:0] v0x, v0y, e0x, e0y, e1x, e1y;
    logic [31:0]        attr;
  } triangle_state_t;

  typedef struct packed {
    logic [15:0]     x;
    logic [15:0]     y;
    triangle_state_t triangle;
  } pixel_state_t;

  typedef struct packed {
    logic signed [16:0] min_x, max_x, min_y, max_y;
  } bbox_t;

  typedef enum logic [1:0] {IDLE, SETUP, WALK} traverser_state_e;

  function automatic logic signed [16:0] smin(input logic signed [16:0] a, input logic signed [16:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [16:0] smax(input logic signed [16:0] a, input logic signed [16:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tri_bbox.sv
// Combinational screen-clipped integer bounding box of a set-up triangle (3 fractional bits).
module tri_bbox
  import rasterizer_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  triangle_state_t triangle,
  output bbox_t           bbox,
  output logic            empty
);

  localparam logic signed [16:0] X_LIM = 17'(WIDTH - 1);
  localparam logic signed [16:0] Y_LIM = 17'(HEIGHT - 1);

  logic signed [16:0] xa, xb, xc, ya, yb, yc;
  logic signed [16:0] lo_x, hi_x, lo_y, hi_y;
  logic signed [17:0] ceil_x, ceil_y;
  logic               unused_bits;

  // Ceil needs an extra bit: the widest vertex plus 7 can overflow 17 bits.
  assign unused_bits = ^{triangle.attr, ceil_x[17], ceil_y[17]};

  always_comb begin
    xa = {triangle.v0x[15], triangle.v0x};
    ya = {triangle.v0y[15], triangle.v0y};
    xb = xa + {triangle.e0x[15], triangle.e0x};
    yb = ya + {triangle.e0y[15], triangle.e0y};
    xc = xa + {triangle.e1x[15], triangle.e1x};
    yc = ya + {triangle.e1y[15], triangle.e1y};
    lo_x = smin(xa, smin(xb, xc));
    hi_x = smax(xa, smax(xb, xc));
    lo_y = smin(ya, smin(yb, yc));
    hi_y = smax(ya, smax(yb, yc));
    ceil_x = $signed({lo_x[16], lo_x} + 18'd7) >>> 3;
    ceil_y = $signed({lo_y[16], lo_y} + 18'd7) >>> 3;
    bbox       = '0;
    bbox.min_x = smax(ceil_x[16:0], 17'sd0);
    bbox.min_y = smax(ceil_y[16:0], 17'sd0);
    bbox.max_x = smin(hi_x >>> 3, X_LIM);
    bbox.max_y = smin(hi_y >>> 3, Y_LIM);
    empty = (bbox.min_x > bbox.max_x) || (bbox.min_y > bbox.max_y);
  end

endmodule

// File: rtl/pixel_traverser.sv
// Walks the clipped bounding box of one triangle in raster order, one pixel per cycle.
// Handshake: a transfer happens on a clock edge where valid and ready are both high; valid never waits on ready, and the payload is held stable while valid is high and ready is low.
module pixel_traverser
  import rasterizer_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic             clk,
  input  logic             rst,
  input  triangle_state_t  in_triangle,
  input  logic             in_valid,
  output logic             in_ready,
  output pixel_state_t     out_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output traverser_state_e dbg_state
);

  traverser_state_e state_q, state_d;
  triangle_state_t  tri_q, tri_d;
  bbox_t            bbox_q, bbox_d;
  logic [15:0]      cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic             out_valid_q, out_valid_d;
  bbox_t            setup_bbox;
  logic             setup_empty;
  logic             unused_bits;

  tri_bbox #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_tri_bbox (
    .triangle (tri_q),
    .bbox     (setup_bbox),
    .empty    (setup_empty)
  );

  // Clipped minima are never negative, so their sign bit carries nothing.
  assign unused_bits = ^{bbox_q.min_x[16], bbox_q.min_y[16]};

  always_comb begin
    state_d     = state_q;
    tri_d       = tri_q;
    bbox_d      = bbox_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tri_d   = in_triangle;
          state_d = SETUP;
        end
      end
      SETUP: begin
        bbox_d = setup_bbox;
        if (setup_empty) begin
          state_d = IDLE;
        end else begin
          cur_x_d     = setup_bbox.min_x[15:0];
          cur_y_d     = setup_bbox.min_y[15:0];
          out_valid_d = 1'b1;
          state_d     = WALK;
        end
      end
      WALK: begin
        if (out_ready) begin
          if ($signed({1'b0, cur_x_q}) < bbox_q.max_x) begin
            cur_x_d = cur_x_q + 16'd1;
          end else if ($signed({1'b0, cur_y_q}) < bbox_q.max_y) begin
            cur_x_d = bbox_q.min_x[15:0];
            cur_y_d = cur_y_q + 16'd1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tri_q       <= '0;
      bbox_q      <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tri_q       <= tri_d;
      bbox_q      <= bbox_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_pixel = {cur_x_q, cur_y_q, tri_q};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pixel_traverser.sv
// Directed and random triangles checked against an arithmetic bounding-box model.
module tb_pixel_traverser;
  import rasterizer_pkg::*;

  localparam int W = 320;
  localparam int H = 240;

  logic             clk = 1'b0;
  logic             rst;
  triangle_state_t  in_triangle;
  logic             in_valid;
  logic             in_ready;
  pixel_state_t     out_pixel;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  traverser_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pixel_traverser #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_triangle (in_triangle),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_pixel   (out_pixel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic triangle_state_t make_tri(input int v0x, input int v0y, input int e0x,
                                               input int e0y, input int e1x, input int e1y);
    triangle_state_t t;
    t.v0x  = 16'(v0x);
    t.v0y  = 16'(v0y);
    t.e0x  = 16'(e0x);
    t.e0y  = 16'(e0y);
    t.e1x  = 16'(e1x);
    t.e1y  = 16'(e1y);
    t.attr = $urandom;
    return t;
  endfunction

  // Real-number style floor/ceil of v/8 using truncating integer division.
  function automatic int floor8(input int v);
    return (v >= 0) ? v / 8 : -((-v + 7) / 8);
  endfunction

  function automatic int ceil8(input int v);
    return -floor8(-v);
  endfunction

  task automatic build_expected(input triangle_state_t t);
    int xs[3];
    int ys[3];
    int lx, hx, ly, hy, x0, x1, y0, y1;
    xs[0] = int'(t.v0x); xs[1] = int'(t.v0x) + int'(t.e0x); xs[2] = int'(t.v0x) + int'(t.e1x);
    ys[0] = int'(t.v0y); ys[1] = int'(t.v0y) + int'(t.e0y); ys[2] = int'(t.v0y) + int'(t.e1y);
    lx = xs[0]; hx = xs[0]; ly = ys[0]; hy = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < lx) lx = xs[i];
      if (xs[i] > hx) hx = xs[i];
      if (ys[i] < ly) ly = ys[i];
      if (ys[i] > hy) hy = ys[i];
    end
    x0 = ceil8(lx);  if (x0 < 0) x0 = 0;
    y0 = ceil8(ly);  if (y0 < 0) y0 = 0;
    x1 = floor8(hx); if (x1 > W - 1) x1 = W - 1;
    y1 = floor8(hy); if (y1 > H - 1) y1 = H - 1;
    exp_q.delete();
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        exp_q.push_back({16'(x), 16'(y)});
  endtask

  // mode 0: ready always high, 1: alternating, 2: random. Entered and left just after a posedge.
  task automatic run_tri(input triangle_state_t t, input int mode, input string tag);
    int n_exp, hs, first_k, last_hs_k, budget, done_k;
    bit stalled;
    logic [159:0] held;
    build_expected(t);
    n_exp  = exp_q.size();
    budget = 16 * n_exp + 20;
    hs = 0; first_k = -1; last_hs_k = 0; done_k = -1; stalled = 0; held = '0;
    check({tag, " in_ready before offer"}, in_ready, 1'b1);
    in_triangle = t;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_triangle = '0;
    for (int k = 1; k <= budget && done_k < 0; k++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((k & 1) == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (stalled) begin
        check({tag, " stall valid"}, out_valid, 1'b1);
        check({tag, " stall hold"}, out_pixel, held);
      end
      stalled = 0;
      if (out_valid) begin
        if (first_k < 0) begin
          first_k = k;
          check({tag, " first pixel latency"}, k, 2);
        end
        if (out_ready) begin
          hs++;
          last_hs_k = k;
          if (exp_q.size() == 0) check({tag, " surplus pixel"}, hs, n_exp);
          else check({tag, " pixel xy"}, {out_pixel.x, out_pixel.y}, exp_q.pop_front());
          check({tag, " triangle pass"}, out_pixel.triangle, t);
        end else begin
          stalled = 1;
          held    = out_pixel;
        end
      end
      if (in_ready) begin
        done_k = k;
        check({tag, " busy at end"}, busy, 1'b0);
        if (n_exp == 0) check({tag, " empty in_ready"}, k, 2);
        else check({tag, " in_ready after last"}, k, last_hs_k + 1);
      end else begin
        check({tag, " busy"}, busy, 1'b1);
      end
      @(posedge clk); #1;
    end
    check({tag, " finished in budget"}, (done_k > 0), 1'b1);
    check({tag, " pixel count"}, hs, n_exp);
  endtask

  initial begin
    triangle_state_t t;
    int hs, k;
    rst = 1'b1; in_valid = 1'b0; in_triangle = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset in_ready forced low", in_ready, 1'b0);
    check("reset out_pixel", out_pixel, '0);
    check("reset state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", in_ready, 1'b1);
    @(posedge clk); #1;

    run_tri(make_tri(8, 8, 16, 0, 0, 16), 0, "basic");
    run_tri(make_tri(8, 8, 16, 0, 0, 16), 1, "backpressure");
    run_tri(make_tri(-16, -16, 40, 0, 0, 40), 0, "clip");
    run_tri(make_tri(9, 8, 5, 16, 2, 0), 0, "subpixel empty");
    run_tri(make_tri(8 * W, 8, 16, 16, 8, 24), 0, "offscreen");
    run_tri(make_tri(8 * (W - 3), 8 * (H - 2), 100, 0, 0, 100), 2, "far corner clip");

    // Reset after the 4th handshake of the basic triangle.
    t = make_tri(8, 8, 16, 0, 0, 16);
    in_triangle = t; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    hs = 0;
    for (k = 0; k < 40 && hs < 4; k++) begin
      @(negedge clk);
      if (out_valid) hs++;
      @(posedge clk); #1;
    end
    check("midwalk handshakes seen", hs, 4);
    rst = 1'b1;
    #1;
    check("midwalk rst out_valid", out_valid, 1'b0);
    check("midwalk rst busy", busy, 1'b0);
    check("midwalk rst out_pixel", out_pixel, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_tri(make_tri(80, 80, 8, 0, 0, 8), 0, "after reset");

    for (int i = 0; i < 20; i++) begin
      t = make_tri(int'($urandom_range(0, 2800)) - 200, int'($urandom_range(0, 2100)) - 200,
                   int'($urandom_range(0, 192)) - 96, int'($urandom_range(0, 192)) - 96,
                   int'($urandom_range(0, 192)) - 96, int'($urandom_range(0, 192)) - 96);
      run_tri(t, int'($urandom_range(0, 2)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
